// File: rtl/camera_capture_if.sv
// Camera byte bus plus frame-buffer write port of the OV7670 capture stage.
// The master drives the camera pins and the slave (camera_capture) drives the write port.
interface camera_capture_if #(
    parameter int ADDR_W = 19
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic              capture_en;
    logic [11:0]       pixel;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              frame_done;
    logic              busy;

    modport master (
        output vsync, href, d, capture_en,
        input  pixel, addr, we, frame_done, busy
    );

    modport slave (
        input  vsync, href, d, capture_en,
        output pixel, addr, we, frame_done, busy
    );
endinterface

// File: rtl/camera_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and writes them linearly to a frame buffer.
// Define CAPTURE_DECIMATE_EN to store only the pixels at even x on even y lines (2:1 decimation in each axis).
module camera_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic             clk,
    input  logic             rst,
    camera_capture_if.slave  cam
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q, href_q;
    logic [7:0]        d_q;
    logic              vsync_p_q, href_p_q;
    logic              phase_q, phase_d;
    logic [3:0]        r_q, r_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              write_frame_q, write_frame_d;
    logic [11:0]       pixel_q, pixel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;

    logic vsync_rise, vsync_fall, href_fall;
    logic keep, wr_ok;

    assign vsync_rise = vsync_q & ~vsync_p_q;
    assign vsync_fall = ~vsync_q & vsync_p_q;
    assign href_fall  = ~href_q & href_p_q;

`ifdef CAPTURE_DECIMATE_EN
    assign keep = ~x_q[0] & ~y_q[0];
`else
    assign keep = 1'b1;
`endif

    assign wr_ok = write_frame_q && (x_q < H_LIM) && (y_q < V_LIM) && keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            d_q           <= '0;
            vsync_p_q     <= 1'b0;
            href_p_q      <= 1'b0;
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            r_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            write_frame_q <= 1'b0;
            pixel_q       <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            vsync_q       <= cam.vsync;
            href_q        <= cam.href;
            d_q           <= cam.d;
            vsync_p_q     <= vsync_q;
            href_p_q      <= href_q;
            state_q       <= state_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            write_frame_q <= write_frame_d;
            pixel_q       <= pixel_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = href_q ? ~phase_q : 1'b0;
        r_d           = r_q;
        x_d           = x_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        write_frame_d = write_frame_q;
        pixel_d       = pixel_q;
        addr_d        = addr_q;
        we_d          = 1'b0;
        frame_done_d  = 1'b0;

        if (href_q && !phase_q) begin
            r_d = d_q[3:0];
        end

        case (state_q)
            IDLE: begin
                // Wait out any frame already in flight at reset.
                if (vsync_q) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (vsync_fall) begin
                    x_d           = '0;
                    y_d           = '0;
                    cnt_d         = '0;
                    write_frame_d = cam.capture_en;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (href_q && phase_q) begin
                    if (wr_ok) begin
                        pixel_d = {r_q, d_q};
                        addr_d  = cnt_q;
                        cnt_d   = cnt_q + ADDR_W'(1);
                        we_d    = 1'b1;
                    end
                    // Saturate so over-long lines cannot wrap back into range.
                    if (x_q < H_LIM) begin
                        x_d = x_q + XW'(1);
                    end
                end
                if (href_fall) begin
                    x_d = '0;
                    if (y_q < V_LIM) begin
                        y_d = y_q + YW'(1);
                    end
                end
                if (vsync_rise) begin
                    frame_done_d = write_frame_q;
                    state_d      = SYNC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cam.pixel      = pixel_q;
    assign cam.addr       = addr_q;
    assign cam.we         = we_q;
    assign cam.frame_done = frame_done_q;
    assign cam.busy       = (state_q == ACTIVE) && write_frame_q;
endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: table-driven pixel frame plus hand-written frame/reset sequences.
module tb_camera_capture;
`ifdef CAPTURE_DECIMATE_EN
    localparam int H = 8;
    localparam int V = 4;
`else
    localparam int H = 4;
    localparam int V = 2;
`endif
    localparam int AW = 19;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    camera_capture_if #(.ADDR_W(AW)) cam();

    camera_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cam(cam)
    );

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] pix;
    } vec_t;

    vec_t tbl[8];

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    logic prev_we = 1'b0;
    logic [AW-1:0] mon_addr[$];
    logic [11:0]   mon_pix[$];

    always @(negedge clk) begin
        if (cam.we === 1'b1) begin
            checks++;
            if (prev_we === 1'b1) begin
                errors++;
                $display("FAIL we_spacing: we high on consecutive cycles, required at most one write per two clocks");
            end
            mon_addr.push_back(cam.addr);
            mon_pix.push_back(cam.pixel);
        end
        if (cam.frame_done === 1'b1) fd_cnt++;
        prev_we = cam.we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat_b0(input int x);
        return 8'hF0 | 8'(x + 1);
    endfunction

    function automatic logic [7:0] pat_b1(input int y);
        logic [3:0] yy;
        yy = 4'(y);
        return {yy, 4'h5};
    endfunction

    function automatic logic [11:0] pat_pix(input int x, input int y);
        logic [3:0] xx;
        logic [3:0] yy;
        xx = 4'(x + 1);
        yy = 4'(y);
        return {xx, yy, 4'h5};
    endfunction

    // Camera coordinates of the k-th stored pixel.
    function automatic int exp_x(input int k);
`ifdef CAPTURE_DECIMATE_EN
        return (k % (H / 2)) * 2;
`else
        return k % H;
`endif
    endfunction

    function automatic int exp_y(input int k);
`ifdef CAPTURE_DECIMATE_EN
        return (k / (H / 2)) * 2;
`else
        return k / H;
`endif
    endfunction

    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
        cam.d = b0;
        tick(1);
        cam.d = b1;
        tick(1);
    endtask

    task automatic send_line(input int npix, input int y, input bit odd);
        cam.href = 1'b1;
        for (int x = 0; x < npix; x++) send_pair(pat_b0(x), pat_b1(y));
        if (odd) begin
            cam.d = 8'h0F;
            tick(1);
        end
        cam.href = 1'b0;
        cam.d    = 8'h00;
        tick(3);
    endtask

    task automatic frame_start(input bit cap);
        cam.vsync      = 1'b1;
        cam.capture_en = cap;
        tick(3);
        cam.vsync = 1'b0;
        tick(2);
    endtask

    task automatic frame_end(input bit exp_fd);
        cam.vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("frame_done_early", 32'(cam.frame_done), 32'd0);
        @(negedge clk);
        chk("frame_done_pulse", 32'(cam.frame_done), 32'(exp_fd));
        @(negedge clk);
        chk("frame_done_width", 32'(cam.frame_done), 32'd0);
        tick(1);
    endtask

    task automatic check_frame(input string name, input int n);
        chk({name, "_count"}, 32'(mon_addr.size()), 32'(n));
        for (int k = 0; k < n && k < mon_addr.size(); k++) begin
            chk({name, "_addr"}, 32'(mon_addr[k]), 32'(k));
            chk({name, "_pixel"}, 32'(mon_pix[k]), 32'(pat_pix(exp_x(k), exp_y(k))));
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_pix.delete();
    endtask

    initial begin
        tbl[0] = '{8'h0A, 8'h5C, 12'hA5C};
        tbl[1] = '{8'hFA, 8'h5C, 12'hA5C};
        tbl[2] = '{8'h03, 8'hFF, 12'h3FF};
        tbl[3] = '{8'h00, 8'h00, 12'h000};
        tbl[4] = '{8'h1F, 8'h12, 12'hF12};
        tbl[5] = '{8'h07, 8'h80, 12'h780};
        tbl[6] = '{8'hC5, 8'h6A, 12'h56A};
        tbl[7] = '{8'h0E, 8'hE1, 12'hEE1};

        rst            = 1'b1;
        cam.vsync      = 1'b0;
        cam.href       = 1'b0;
        cam.d          = 8'h00;
        cam.capture_en = 1'b1;
        tick(3);
        chk("reset_pixel", 32'(cam.pixel), 32'd0);
        chk("reset_addr", 32'(cam.addr), 32'd0);
        chk("reset_we", 32'(cam.we), 32'd0);
        chk("reset_frame_done", 32'(cam.frame_done), 32'd0);
        chk("reset_busy", 32'(cam.busy), 32'd0);
        rst = 1'b0;
        tick(1);

        // Stimulus starting mid-frame must be ignored.
        send_line(H, 0, 1'b0);
        send_line(H, 1, 1'b0);
        chk("midframe_no_we", 32'(mon_addr.size()), 32'd0);
        frame_start(1'b1);
        chk("no_fd_from_idle", 32'(fd_cnt), 32'd0);
        chk("busy_active", 32'(cam.busy), 32'd1);

`ifdef CAPTURE_DECIMATE_EN
        for (int y = 0; y < V; y++) send_line(H, y, 1'b0);
        frame_end(1'b1);
        check_frame("decimate", NW);
`else
        for (int l = 0; l < V; l++) begin
            cam.href = 1'b1;
            for (int i = 0; i < H; i++) send_pair(tbl[l*H+i].b0, tbl[l*H+i].b1);
            cam.href = 1'b0;
            tick(3);
        end
        frame_end(1'b1);
        chk("table_count", 32'(mon_addr.size()), 32'(NW));
        for (int k = 0; k < NW && k < mon_addr.size(); k++) begin
            chk("table_addr", 32'(mon_addr[k]), 32'(k));
            chk("table_pixel", 32'(mon_pix[k]), 32'(tbl[k].pix));
        end
        chk("busy_after_frame", 32'(cam.busy), 32'd0);

        clear_mon();
        frame_start(1'b0);
        chk("skip_busy", 32'(cam.busy), 32'd0);
        for (int y = 0; y < V; y++) send_line(H, y, 1'b0);
        frame_end(1'b0);
        chk("skip_count", 32'(mon_addr.size()), 32'd0);

        clear_mon();
        frame_start(1'b1);
        for (int y = 0; y < V; y++) send_line(H, y, 1'b0);
        frame_end(1'b1);
        check_frame("resume", NW);

        clear_mon();
        frame_start(1'b1);
        send_line(6, 0, 1'b1);
        send_line(6, 1, 1'b0);
        send_line(6, 2, 1'b0);
        frame_end(1'b1);
        check_frame("overlong", NW);
        if (mon_addr.size() > 0) chk("overlong_last_addr", 32'(mon_addr[mon_addr.size()-1]), 32'd7);
`endif

        // One-cycle reset in the middle of a line.
        clear_mon();
        frame_start(1'b1);
        cam.href = 1'b1;
        send_pair(pat_b0(0), pat_b1(0));
        send_pair(pat_b0(1), pat_b1(0));
        rst   = 1'b1;
        cam.d = pat_b0(2);
        tick(1);
        chk("rst_we", 32'(cam.we), 32'd0);
        chk("rst_busy", 32'(cam.busy), 32'd0);
        chk("rst_addr", 32'(cam.addr), 32'd0);
        chk("rst_pixel", 32'(cam.pixel), 32'd0);
        rst = 1'b0;
        clear_mon();
        cam.d = pat_b1(0);
        tick(1);
        send_pair(pat_b0(3), pat_b1(0));
        cam.href = 1'b0;
        tick(3);
        send_line(H, 1, 1'b0);
        chk("rst_no_we", 32'(mon_addr.size()), 32'd0);
        frame_end(1'b0);
        frame_start(1'b1);
        for (int y = 0; y < V; y++) send_line(H, y, 1'b0);
        frame_end(1'b1);
        check_frame("after_rst", NW);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
